// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// The controller side is the master: it consumes the decoded instruction
// fields, the ALU zero flag and the memory handshake, and drives every
// enable and mux select.
interface multicycle_control_if;
    logic [10:0] instruction;
    logic        zero;
    logic        mem_ready;
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemRead;
    logic        MemWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [3:0]  ALUOp;
    logic        Branch;
    logic        illegal;
    logic        error;
    logic [3:0]  state_dbg;

    modport master (
        input  instruction, zero, mem_ready,
        output PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ALUOp, Branch,
        output illegal, error, state_dbg
    );

    modport slave (
        output instruction, zero, mem_ready,
        input  PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, Branch,
        input  illegal, error, state_dbg
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore-style sequencer for the multicycle RV32I datapath. Walks each
// instruction through fetch/decode/execute/writeback, stalls on memory
// wait states, drops into a sticky ERROR state if memory never answers,
// and flags opcodes it does not implement.
module multicycle_control #(
    parameter int TIMEOUT = 15,
    parameter int CW      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_ERROR    = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            waiting;

    logic            pcwrite_c, adrsrc_c, memread_c, memwrite_c;
    logic            irwrite_c, regwrite_c, branch_c, illegal_c;
    logic [1:0]      result_c, srca_c, srcb_c;
    logic [3:0]      aluop_c;

    assign opcode   = bus.instruction[6:0];
    assign funct3   = bus.instruction[9:7];
    assign funct7b5 = bus.instruction[10];

    // The watchdog only runs in the states that stall on mem_ready.
    assign waiting = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                     (state_q == S_MEMWRITE);

    // funct3 -> ALU operation; the funct7 bit only selects SUB for
    // register-register ops, but always selects SRA on right shifts.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                              input logic       f7b5,
                                              input logic       is_reg);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
            3'b111:  op = 4'b0010;
            3'b110:  op = 4'b0011;
            3'b100:  op = 4'b0100;
            3'b010:  op = 4'b0101;
            3'b001:  op = 4'b0110;
            3'b101:  op = f7b5 ? 4'b1000 : 4'b0111;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // State and watchdog registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, watchdog and per-state control outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        pcwrite_c  = 1'b0;
        adrsrc_c   = 1'b0;
        memread_c  = 1'b0;
        memwrite_c = 1'b0;
        irwrite_c  = 1'b0;
        regwrite_c = 1'b0;
        branch_c   = 1'b0;
        illegal_c  = 1'b0;
        result_c   = 2'b00;
        srca_c     = 2'b00;
        srcb_c     = 2'b00;
        aluop_c    = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                memread_c = 1'b1;
                srcb_c    = 2'b10;
                result_c  = 2'b10;
                irwrite_c = bus.mem_ready;
                pcwrite_c = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                srca_c = 2'b01;
                srcb_c = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BRANCH:         state_d = S_BRANCH;
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                srca_c  = 2'b10;
                srcb_c  = 2'b01;
                state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adrsrc_c  = 1'b1;
                memread_c = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_c   = 2'b01;
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adrsrc_c   = 1'b1;
                memwrite_c = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                srca_c  = 2'b10;
                srcb_c  = 2'b00;
                aluop_c = alu_decode(funct3, funct7b5, 1'b1);
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                srca_c  = 2'b10;
                srcb_c  = 2'b01;
                aluop_c = alu_decode(funct3, funct7b5, 1'b0);
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                srca_c    = 2'b01;
                srcb_c    = 2'b10;
                pcwrite_c = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BRANCH: begin
                srca_c    = 2'b10;
                srcb_c    = 2'b00;
                aluop_c   = ALU_SUB;
                branch_c  = 1'b1;
                pcwrite_c = bus.zero ^ funct3[0];
                state_d   = S_FETCH;
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_FETCH;
        endcase

        // Count stalled cycles; the TIMEOUT-th stalled cycle is the last one
        // allowed, so a ready on that cycle still completes normally.
        if (waiting && !bus.mem_ready) begin
            if (cnt_q == CW'(TIMEOUT - 1)) begin
                state_d = S_ERROR;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Strobes are gated by rst so an in-flight access dies the moment reset
    // arrives rather than at the next edge.
    assign bus.PCWrite   = pcwrite_c  & ~rst;
    assign bus.MemRead   = memread_c  & ~rst;
    assign bus.MemWrite  = memwrite_c & ~rst;
    assign bus.IRWrite   = irwrite_c  & ~rst;
    assign bus.RegWrite  = regwrite_c & ~rst;
    assign bus.illegal   = illegal_c  & ~rst;
    assign bus.AdrSrc    = adrsrc_c;
    assign bus.ResultSrc = result_c;
    assign bus.ALUSrcA   = srca_c;
    assign bus.ALUSrcB   = srcb_c;
    assign bus.ALUOp     = aluop_c;
    assign bus.Branch    = branch_c;
    assign bus.error     = (state_q == S_ERROR);
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Each instruction is expanded into
// the expected sequence of states (from its class and the memory delays
// chosen), each state into its expected control word, and a negedge
// compare process checks the DUT every cycle.
module tb_multicycle_control;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;

    multicycle_control_if bus();

    multicycle_control #(.TIMEOUT(TIMEOUT), .CW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, mrd, mwr, irw, rgw;
        logic [1:0] res, sa, sb;
        logic [3:0] op;
        logic       br, ill, err;
    } ctl_t;

    typedef struct {
        int st;
        bit mr;
    } step_t;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    bit   exp_valid   = 0;
    ctl_t exp_c;
    ctl_t act;

    int         memwrite_cycles = 0;
    logic [3:0] last_exec_op    = 4'hx;
    logic       last_branch_pcw = 1'bx;

    assign act = {bus.state_dbg, bus.PCWrite, bus.AdrSrc, bus.MemRead,
                  bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.ResultSrc,
                  bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.Branch,
                  bus.illegal, bus.error};

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    function automatic logic [10:0] mk(input logic f7, input logic [2:0] f3,
                                       input logic [6:0] op);
        return {f7, f3, op};
    endfunction

    // ALU operation implied by an ALU instruction.
    function automatic logic [3:0] model_alu(input logic [10:0] ins,
                                             input bit is_reg);
        logic [3:0] by_f3 [8];
        logic [3:0] r;
        by_f3 = '{4'd0, 4'd6, 4'd5, 4'd0, 4'd4, 4'd7, 4'd3, 4'd2};
        r = by_f3[ins[9:7]];
        if (ins[9:7] == 3'd0 && is_reg && ins[10]) r = 4'd1;
        if (ins[9:7] == 3'd5 && ins[10]) r = 4'd8;
        return r;
    endfunction

    function automatic bit legal_op(input logic [6:0] op);
        return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                          7'b1101111, 7'b1100011};
    endfunction

    // Control word the datapath must see in a given state.
    function automatic ctl_t model_ctl(input int st, input logic [10:0] ins,
                                       input logic z, input bit mr);
        ctl_t c;
        c = '0;
        c.st = 4'(st);
        case (st)
            0:  begin c.mrd = 1; c.sb = 2; c.res = 2; c.irw = mr; c.pcw = mr; end
            1:  begin c.sa = 1; c.sb = 1; c.ill = !legal_op(ins[6:0]); end
            2:  begin c.sa = 2; c.sb = 1; end
            3:  begin c.adr = 1; c.mrd = 1; end
            4:  begin c.res = 1; c.rgw = 1; end
            5:  begin c.adr = 1; c.mwr = 1; end
            6:  begin c.sa = 2; c.sb = 0; c.op = model_alu(ins, 1); end
            7:  begin c.rgw = 1; end
            8:  begin c.sa = 2; c.sb = 1; c.op = model_alu(ins, 0); end
            9:  begin c.sa = 1; c.sb = 2; c.pcw = 1; end
            10: begin c.sa = 2; c.sb = 0; c.op = 4'd1; c.br = 1; c.pcw = z ^ ins[7]; end
            15: begin c.err = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic step_t stp(input int st, input bit mr);
        step_t s;
        s.st = st;
        s.mr = mr;
        return s;
    endfunction

    // Execute one instruction: fw stalled fetch cycles, mw stalled cycles in
    // the data-memory state (>= TIMEOUT means memory never answers).
    task automatic run(input logic [10:0] ins, input int fw, input int mw,
                       input logic z);
        step_t q[$];
        int    s;
        for (int i = 0; i < fw; i++) q.push_back(stp(0, 0));
        q.push_back(stp(0, 1));
        q.push_back(stp(1, 0));
        case (ins[6:0])
            7'b0000011, 7'b0100011: begin
                q.push_back(stp(2, 0));
                s = (ins[6:0] == 7'b0000011) ? 3 : 5;
                if (mw >= TIMEOUT) begin
                    for (int i = 0; i < TIMEOUT; i++) q.push_back(stp(s, 0));
                    for (int i = 0; i < 3; i++) q.push_back(stp(15, 0));
                end else begin
                    for (int i = 0; i < mw; i++) q.push_back(stp(s, 0));
                    q.push_back(stp(s, 1));
                    if (s == 3) q.push_back(stp(4, 0));
                end
            end
            7'b0110011: begin q.push_back(stp(6, 0)); q.push_back(stp(7, 0)); end
            7'b0010011: begin q.push_back(stp(8, 0)); q.push_back(stp(7, 0)); end
            7'b1101111: begin q.push_back(stp(9, 0)); q.push_back(stp(7, 0)); end
            7'b1100011: q.push_back(stp(10, 0));
            default: ;
        endcase
        bus.instruction = ins;
        bus.zero        = z;
        foreach (q[i]) begin
            bus.mem_ready = q[i].mr;
            exp_c         = model_ctl(q[i].st, ins, z, q[i].mr);
            exp_valid     = 1;
            cyc++;
            @(posedge clk);
            #1;
        end
        exp_valid = 0;
    endtask

    // Per-cycle comparison against the model, plus a few observations used
    // by the literal checks.
    always @(negedge clk) begin
        if (exp_valid) begin
            check($sformatf("cyc%0d_state%0d", cyc, exp_c.st),
                  32'(act), 32'(exp_c));
            if (bus.state_dbg == 4'd5) memwrite_cycles++;
            if (bus.state_dbg == 4'd6 || bus.state_dbg == 4'd8)
                last_exec_op = bus.ALUOp;
            if (bus.state_dbg == 4'd10) last_branch_pcw = bus.PCWrite;
        end
    end

    initial begin
        bus.instruction = '0;
        bus.zero        = 1'b0;
        bus.mem_ready   = 1'b1;

        // In reset with memory ready: strobes forced low, FETCH selects.
        @(negedge clk);
        check("rst_state",   32'(bus.state_dbg), 32'd0);
        check("rst_memread", 32'(bus.MemRead),   32'd0);
        check("rst_irwrite", 32'(bus.IRWrite),   32'd0);
        check("rst_pcwrite", 32'(bus.PCWrite),   32'd0);
        check("rst_error",   32'(bus.error),     32'd0);
        check("rst_alusrcb", 32'(bus.ALUSrcB),   32'd2);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.mem_ready = 1'b0;

        run(mk(0, 3'b000, 7'b0110011), 0, 0, 0);   // add
        check("add_aluop", 32'(last_exec_op), 32'd0);
        run(mk(1, 3'b000, 7'b0110011), 0, 0, 0);   // sub
        check("sub_aluop", 32'(last_exec_op), 32'd1);
        run(mk(0, 3'b010, 7'b0000011), 2, 3, 0);   // lw, slow memory
        run(mk(0, 3'b010, 7'b0100011), 0, 2, 0);   // sw
        run(mk(0, 3'b000, 7'b1100011), 0, 0, 1);   // beq taken
        check("beq_z1", 32'(last_branch_pcw), 32'd1);
        run(mk(0, 3'b000, 7'b1100011), 0, 0, 0);   // beq not taken
        check("beq_z0", 32'(last_branch_pcw), 32'd0);
        run(mk(0, 3'b001, 7'b1100011), 0, 0, 1);   // bne, zero
        check("bne_z1", 32'(last_branch_pcw), 32'd0);
        run(mk(0, 3'b001, 7'b1100011), 0, 0, 0);   // bne, nonzero
        check("bne_z0", 32'(last_branch_pcw), 32'd1);
        run(mk(0, 3'b000, 7'b1101111), 1, 0, 0);   // jal
        run(mk(1, 3'b000, 7'b0010011), 0, 0, 0);   // addi, f7 bit ignored
        check("addi_aluop", 32'(last_exec_op), 32'd0);
        run(mk(1, 3'b101, 7'b0010011), 0, 0, 0);   // srai
        check("srai_aluop", 32'(last_exec_op), 32'd8);
        run(mk(0, 3'b111, 7'b0110011), 0, 0, 0);   // and
        check("and_aluop", 32'(last_exec_op), 32'd2);
        run(mk(0, 3'b010, 7'b0110011), 0, 0, 0);   // slt
        run(mk(0, 3'b001, 7'b0110011), 0, 0, 0);   // sll
        run(mk(0, 3'b100, 7'b0010011), 0, 0, 0);   // xori
        run(mk(0, 3'b110, 7'b0010011), 0, 0, 0);   // ori
        run(mk(0, 3'b101, 7'b0110011), 0, 0, 0);   // srl
        run(mk(0, 3'b010, 7'b0000011), 0, TIMEOUT - 1, 0); // ready on last allowed cycle
        run(mk(0, 3'b000, 7'b0000000), 0, 0, 0);   // illegal opcode

        // Reset arriving mid-FETCH kills IRWrite immediately.
        bus.mem_ready = 1'b1;
        #1;
        check("fetch_irwrite_pre", 32'(bus.IRWrite), 32'd1);
        rst = 1'b1;
        #1;
        check("fetch_irwrite_rst", 32'(bus.IRWrite), 32'd0);
        check("fetch_pcwrite_rst", 32'(bus.PCWrite), 32'd0);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        check("fetch_after_rst", 32'(bus.state_dbg), 32'd0);

        // Store that never completes: 15 MEMWRITE cycles, then ERROR.
        memwrite_cycles = 0;
        run(mk(0, 3'b010, 7'b0100011), 0, TIMEOUT, 0);
        check("timeout_memwrite_cycles", 32'(memwrite_cycles), 32'd15);
        check("timeout_error",    32'(bus.error),     32'd1);
        check("timeout_memwrite", 32'(bus.MemWrite),  32'd0);
        check("timeout_state",    32'(bus.state_dbg), 32'd15);
        rst = 1'b1;
        #1;
        check("err_rst_state", 32'(bus.state_dbg), 32'd0);
        check("err_rst_error", 32'(bus.error),     32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset arriving mid-MEMWRITE drops MemWrite at once.
        bus.instruction = mk(0, 3'b010, 7'b0100011);
        bus.mem_ready   = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("sw_mid_state",    32'(bus.state_dbg), 32'd5);
        check("sw_mid_memwrite", 32'(bus.MemWrite),  32'd1);
        rst = 1'b1;
        #1;
        check("sw_rst_memwrite", 32'(bus.MemWrite),  32'd0);
        check("sw_rst_state",    32'(bus.state_dbg), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run(mk(0, 3'b000, 7'b0110011), 0, 0, 0);   // resumes normally

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style FSM that sequences the multicycle RV32I datapath (shared ALU, shared instruction/data memory port, IR, ALUOut and Data registers).
- Decodes the same 11-bit packed instruction field and the ALU zero flag used by the single-cycle decoder.
- Issues per-cycle enables and mux selects for the datapath.
- Adds memory wait-state handshaking, a timeout watchdog and illegal-opcode flagging.

Parameters:
- TIMEOUT, 15: maximum cycles spent waiting for mem_ready in one memory state before entering ERROR.
- CW, 4: width of the timeout counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instruction  in  11  [6:0]=opcode, [9:7]=funct3, [10]=funct7 bit5; driven from IR, valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  IR and OldPC enable.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  result mux select: 00=ALUOut, 01=Data, 10=ALUResult.
- ALUSrcA  out  2  ALU A select: 00=PC, 01=OldPC, 10=rs1.
- ALUSrcB  out  2  ALU B select: 00=rs2, 01=imm, 10=constant 4.
- ALUOp  out  4  ALU operation: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLL, 0111 SRL, 1000 SRA.
- Branch  out  1  asserted in BEQ state.
- illegal  out  1  one-cycle pulse when an unsupported opcode is decoded.
- error  out  1  sticky; high while in ERROR.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset (asynchronous): state=FETCH, timeout counter=0, error=0.
  - While rst=1, PCWrite, MemRead, MemWrite, IRWrite, RegWrite and illegal are forced to 0.
  - Selects take their FETCH values.
- Unlisted outputs are 0 in every state.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BRANCH=10, ERROR=15.
- FETCH:
  - Outputs: AdrSrc=0, MemRead=1, ALUSrcA=00, ALUSrcB=10, ALUOp=ADD, ResultSrc=10.
  - IRWrite and PCWrite = mem_ready.
  - Goes to DECODE on mem_ready; otherwise holds.
- DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=01, ADD (branch target into ALUOut).
  - Next state by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1101111 -> JAL; 1100011 -> BRANCH.
  - Any other opcode: illegal=1 and go to FETCH.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ADD. Go to MEMREAD if opcode 0000011, else MEMWRITE.
- MEMREAD: AdrSrc=1, MemRead=1. Go to MEMWB on mem_ready.
- MEMWB: ResultSrc=01, RegWrite=1. Go to FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1, held until mem_ready. Go to FETCH on mem_ready.
- EXECR:
  - ALUSrcA=10, ALUSrcB=00.
  - ALUOp by funct3: 000 -> SUB if funct7b5 else ADD; 111 AND; 110 OR; 100 XOR; 010 SLT; 001 SLL; 101 -> SRA if funct7b5 else SRL.
  - Go to ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01. Same funct3 map, except 000 is always ADD. Go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Go to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=00, PCWrite=1 (PC<=target held in ALUOut). Go to ALUWB (rd<=OldPC+4).
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, SUB, ResultSrc=00, Branch=1.
  - PCWrite = zero XOR funct3[0] (BEQ when funct3=000, BNE when 001); combinational on zero.
  - Go to FETCH.
- Timeout watchdog:
  - Counter clears on entry to FETCH, MEMREAD or MEMWRITE and on mem_ready.
  - Counter increments each cycle in those states while mem_ready=0.
  - When the counter reaches TIMEOUT with mem_ready=0, go to ERROR.
  - mem_ready=1 on the TIMEOUT cycle completes normally.
- ERROR: all enables 0, error=1; only rst exits.
- Reset asserted mid-instruction (e.g. during MEMWRITE): MemWrite drops asynchronously in the same cycle and execution resumes at FETCH.

Test Plan:
- Reset, then mem_ready=1 constantly with add (opcode 0110011, f3=000, f7b5=0):
  - States 0,1,6,7,0.
  - ALUOp=0000 in EXECR.
  - RegWrite=1 only in ALUWB.
  - Same sequence with f7b5=1 gives ALUOp=0001.
- lw, with mem_ready low for 3 cycles in MEMREAD:
  - States 0,1,2,3,3,3,3,4,0.
  - MemRead=1 and AdrSrc=1 throughout MEMREAD.
  - ResultSrc=01 and RegWrite=1 in MEMWB.
- beq (f3=000):
  - zero=1 gives PCWrite=1 in BRANCH.
  - zero=0 gives PCWrite=0.
  - bne (f3=001) inverts both results.
- jal:
  - States 0,1,9,7,0.
  - PCWrite=1 in JAL.
  - RegWrite=1 in ALUWB.
- sw with mem_ready held 0 and TIMEOUT=15:
  - MEMWRITE held for exactly 15 cycles, then ERROR with error=1 and MemWrite=0.
  - Asserting rst returns to FETCH with error=0.
- Opcode 0000000: illegal pulses 1 cycle in DECODE, then FETCH. rst asserted mid-FETCH clears IRWrite asynchronously.
